turbo_clk_gen: RTL and testbench
================================

TURBO_CLK_GEN -- requirements
Module: turbo_clk_gen

Interface
REQ-001 SHALL have parameter MODES, default 4: number of selectable CPU speed modes (2..16).
REQ-002 SHALL have parameter DIV_W, default 4: width of each divider entry.
REQ-003 SHALL have parameter DIVS, default 16'hF731: packed MODES*DIV_W table; entry k (bits k*DIV_W +: DIV_W) = divisor-1 for mode k (default ÷2, ÷4, ÷8, ÷16).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for i_mode (>=2).
REQ-005 SHALL have parameter RST_MODE, default 0: mode selected out of reset.
REQ-006 SHALL have a single clock; reset is synchronous and active-high.
REQ-007 i_clk  input  1  system clock; all state on rising edge.
REQ-008 i_reset  input  1  synchronous active-high reset.
REQ-009 i_mode  input  $clog2(MODES)+1  requested speed mode, asynchronous to i_clk (config switches).
REQ-010 i_wait_req  input  1  peripheral wait-state request, synchronous.
REQ-011 o_clk_en  output  1  single-cycle CPU clock-enable strobe.
REQ-012 o_phase  output  1  toggles on every o_clk_en (CPU two-phase reference).
REQ-013 o_mode_cur  output  $clog2(MODES)  mode currently applied to the divider.
REQ-014 o_mode_chg  output  1  one-cycle pulse when a new mode is applied.
REQ-015 o_mode_err  output  1  one-cycle pulse when a synchronised request >= MODES is first seen.
REQ-016 o_wait_ack  output  1  high while a strobe is being withheld for i_wait_req.
REQ-017 o_en_cnt  output  16  count of issued strobes, wraps modulo 2^16.

Function
REQ-018 i_mode SHALL pass through SYNC_STAGES flops; only the last stage (msync) is used.
REQ-019 Down-counter cnt (DIV_W bits) SHALL decrement each cycle in state COUNT while non-zero.
REQ-020 FSM states SHALL be COUNT and WAIT only.
REQ-021 COUNT, cnt==0, i_wait_req==0: o_clk_en=1 that cycle, cnt reloads DIVS[applied mode], stay COUNT.
REQ-022 COUNT, cnt==0, i_wait_req==1: no strobe, go WAIT, cnt held at 0.
REQ-023 WAIT: o_wait_ack=1; when i_wait_req==0 strobe issues that same cycle, reload, return COUNT; strobe spacing thereafter restarts from reload.
REQ-024 i_wait_req while cnt!=0 SHALL be ignored (no stretch).
REQ-025 Pending mode register SHALL capture msync when msync < MODES and differs from o_mode_cur.
REQ-026 Pending mode SHALL be applied only at a reload (strobe) cycle: reload value uses the new mode's entry, o_mode_cur updates, o_mode_chg pulses that cycle; no shortened or doubled strobe ever.
REQ-027 Multiple requests before a reload: last valid one wins; request equal to o_mode_cur cancels pending.
REQ-028 msync >= MODES: ignored, pending unchanged, o_mode_err pulses once per transition into invalid value.
REQ-029 Entry value 0 (÷1): o_clk_en SHALL be high every cycle not withheld by wait.
REQ-030 o_phase and o_en_cnt SHALL update in the strobe cycle (registered, visible next cycle); o_en_cnt 16'hFFFF -> 16'h0000.
REQ-031 All outputs SHALL be registered except o_clk_en and o_wait_ack, which decode FSM/cnt/i_wait_req (i_wait_req->o_clk_en combinational path allowed).

Reset
REQ-032 i_reset SHALL, same edge: state=COUNT, cnt=DIVS[RST_MODE], o_mode_cur=RST_MODE, pending cleared, synchroniser flops=RST_MODE, o_phase=0, o_en_cnt=0, o_mode_chg=0, o_mode_err=0.
REQ-033 During reset o_clk_en=0 and o_wait_ack=0; reset mid-WAIT or with pending mode SHALL discard both.
REQ-034 First strobe after reset release SHALL occur DIVS[RST_MODE]+1 cycles after the release edge.

Verification
REQ-035 Defaults, i_mode=0 held: strobes every 2 cycles, o_phase toggles each strobe, o_en_cnt=10 after 10 strobes.
REQ-036 Mode 1->3 requested mid-period: strobe spacing 4 until next strobe, then 16; o_mode_chg single pulse at that strobe; no gap <4.
REQ-037 Mode 3, i_wait_req high 5 cycles covering cnt==0: o_wait_ack high, strobe delayed exactly until wait drops, then spacing 16.
REQ-038 i_mode=5 (>=MODES): o_mode_err one pulse, o_mode_cur unchanged, spacing unchanged.
REQ-039 Reset asserted during WAIT with pending mode 2: after release o_mode_cur=0, first strobe 2 cycles later, o_en_cnt=0.
REQ-040 65537 strobes: o_en_cnt wraps to 1.

Source files
------------

// File: rtl/turbo_clk_gen.sv
// Turbo CPU clock-enable generator: divides i_clk into a single-cycle strobe at a
// rate picked by a synchronised mode request, with peripheral wait-state stretching.

module turbo_clk_gen #(
  parameter int                     MODES       = 4,
  parameter int                     DIV_W       = 4,
  parameter logic [MODES*DIV_W-1:0] DIVS        = 16'hF731,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     RST_MODE    = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [$clog2(MODES):0]   i_mode,
  input  logic                     i_wait_req,
  output logic                     o_clk_en,
  output logic                     o_phase,
  output logic [$clog2(MODES)-1:0] o_mode_cur,
  output logic                     o_mode_chg,
  output logic                     o_mode_err,
  output logic                     o_wait_ack,
  output logic [15:0]              o_en_cnt
);

  localparam int               MW      = $clog2(MODES);
  localparam logic [MW:0]      MODES_L = MODES[MW:0];
  localparam logic [MW-1:0]    RST_L   = RST_MODE[MW-1:0];
  localparam logic [DIV_W-1:0] RST_DIV = DIVS[RST_MODE*DIV_W +: DIV_W];

  typedef enum logic {
    ST_COUNT,
    ST_WAIT
  } state_e;

  logic [DIV_W-1:0] div_tab [MODES];

  genvar g;
  generate
    for (g = 0; g < MODES; g++) begin : g_tab
      assign div_tab[g] = DIVS[g*DIV_W +: DIV_W];
    end
  endgenerate

  logic [MW:0]      sync_q [SYNC_STAGES];
  logic [MW:0]      sync_d [SYNC_STAGES];
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    mode_cur_q, mode_cur_d;
  logic             pend_valid_q, pend_valid_d;
  logic [MW-1:0]    pend_mode_q, pend_mode_d;
  logic             bad_q, bad_d;
  logic             mode_chg_q, mode_chg_d;
  logic             mode_err_q, mode_err_d;
  logic             phase_q, phase_d;
  logic [15:0]      en_cnt_q, en_cnt_d;

  logic [MW:0]      msync;
  logic             msync_ok;
  logic             strobe;

  always_comb begin
    sync_d[0] = i_mode;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // WAIT always holds cnt at zero, so a zero count with no wait request is the
  // single condition for a strobe in either state.
  always_comb begin
    msync    = sync_q[SYNC_STAGES-1];
    msync_ok = (msync < MODES_L);
    strobe   = !i_reset && (cnt_q == '0) && !i_wait_req;

    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    phase_d      = phase_q;
    en_cnt_d     = en_cnt_q;
    mode_cur_d   = (strobe && pend_valid_q) ? pend_mode_q : mode_cur_q;
    mode_chg_d   = strobe && pend_valid_q;
    bad_d        = !msync_ok;
    mode_err_d   = !msync_ok && !bad_q;

    if (strobe) begin
      state_d      = ST_COUNT;
      cnt_d        = div_tab[mode_cur_d];
      pend_valid_d = 1'b0;
      phase_d      = ~phase_q;
      en_cnt_d     = en_cnt_q + 16'd1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      state_d = ST_WAIT;
    end

    // Compare against the mode in force after this cycle so a request that was
    // just applied is not captured a second time.
    if (msync_ok) begin
      if (msync[MW-1:0] != mode_cur_d) begin
        pend_valid_d = 1'b1;
        pend_mode_d  = msync[MW-1:0];
      end else begin
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {1'b0, RST_L};
      end
      state_q      <= ST_COUNT;
      cnt_q        <= RST_DIV;
      mode_cur_q   <= RST_L;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= RST_L;
      bad_q        <= 1'b0;
      mode_chg_q   <= 1'b0;
      mode_err_q   <= 1'b0;
      phase_q      <= 1'b0;
      en_cnt_q     <= 16'd0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_cur_q   <= mode_cur_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      bad_q        <= bad_d;
      mode_chg_q   <= mode_chg_d;
      mode_err_q   <= mode_err_d;
      phase_q      <= phase_d;
      en_cnt_q     <= en_cnt_d;
    end
  end

  assign o_clk_en   = strobe;
  assign o_wait_ack = !i_reset && (state_q == ST_WAIT);
  assign o_phase    = phase_q;
  assign o_mode_cur = mode_cur_q;
  assign o_mode_chg = mode_chg_q;
  assign o_mode_err = mode_err_q;
  assign o_en_cnt   = en_cnt_q;

endmodule

// File: tb/tb_turbo_clk_gen.sv
// Self-checking bench for turbo_clk_gen: strobe times are scoreboarded against
// expected cycle offsets from reset release; a second instance with a divide-by-1 entry covers wrap.

module tb_turbo_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b1, i_wait_req = 1'b0;
  logic [2:0]  i_mode = 3'd0;
  logic        o_clk_en, o_phase, o_mode_chg, o_mode_err, o_wait_ack;
  logic [1:0]  o_mode_cur;
  logic [15:0] o_en_cnt;

  logic        f_reset = 1'b1, f_wait = 1'b0;
  logic [2:0]  f_mode = 3'd0;
  logic        f_clk_en, f_phase, f_mode_chg, f_mode_err, f_wait_ack;
  logic [1:0]  f_mode_cur;
  logic [15:0] f_en_cnt;

  turbo_clk_gen dut (
    .i_clk(clk), .i_reset(i_reset), .i_mode(i_mode), .i_wait_req(i_wait_req),
    .o_clk_en(o_clk_en), .o_phase(o_phase), .o_mode_cur(o_mode_cur),
    .o_mode_chg(o_mode_chg), .o_mode_err(o_mode_err), .o_wait_ack(o_wait_ack),
    .o_en_cnt(o_en_cnt)
  );

  turbo_clk_gen #(.DIVS(16'hF730)) dut_fast (
    .i_clk(clk), .i_reset(f_reset), .i_mode(f_mode), .i_wait_req(f_wait),
    .o_clk_en(f_clk_en), .o_phase(f_phase), .o_mode_cur(f_mode_cur),
    .o_mode_chg(f_mode_chg), .o_mode_err(f_mode_err), .o_wait_ack(f_wait_ack),
    .o_en_cnt(f_en_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$], seen_q[$], exp_chg_q[$], chg_q[$], exp_err_q[$], err_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (o_clk_en === 1'b1) seen_q.push_back(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete(); seen_q.delete(); exp_chg_q.delete();
    chg_q.delete(); exp_err_q.delete(); err_q.delete();
  endtask

  task automatic do_reset(input logic [2:0] m, output int r);
    i_reset = 1'b1; i_wait_req = 1'b0; i_mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0; i_mode = m;
    r = cyc;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_wait_req = 1'b0; i_mode = 3'd0;
    repeat (2) @(posedge clk);
    #4;
    checks++; if (o_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk_en: got %b expected 0", o_clk_en); end
    checks++; if (o_wait_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_wait_ack: got %b expected 0", o_wait_ack); end
    checks++; if (o_phase !== 1'b0) begin failures++; $display("[TB] FAIL reset_phase: got %b expected 0", o_phase); end
    checks++; if (o_en_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_en_cnt: got %0d expected 0", o_en_cnt); end
    checks++; if (o_mode_cur !== 2'd0) begin failures++; $display("[TB] FAIL reset_mode_cur: got %0d expected 0", o_mode_cur); end
    checks++; if (o_mode_chg !== 1'b0) begin failures++; $display("[TB] FAIL reset_mode_chg: got %b expected 0", o_mode_chg); end
    checks++; if (o_mode_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_mode_err: got %b expected 0", o_mode_err); end
  endtask

  task automatic test_default();
    int r;
    clear_queues();
    for (int j = 0; j < 10; j++) exp_q.push_back(1 + 2*j);
    do_reset(3'd0, r);
    for (int c = 1; c <= 20; c++) begin
      tick(); #3;
      if (c == 2) begin
        checks++; if (o_en_cnt !== 16'd1) begin failures++; $display("[TB] FAIL default_first_cnt: got %0d expected 1", o_en_cnt); end
        checks++; if (o_phase !== 1'b1) begin failures++; $display("[TB] FAIL default_first_phase: got %b expected 1", o_phase); end
        checks++; if (o_wait_ack !== 1'b0) begin failures++; $display("[TB] FAIL default_wait_ack: got %b expected 0", o_wait_ack); end
      end
    end
    checks++; if (o_en_cnt !== 16'd10) begin failures++; $display("[TB] FAIL default_en_cnt: got %0d expected 10", o_en_cnt); end
    checks++; if (o_phase !== 1'b0) begin failures++; $display("[TB] FAIL default_phase: got %b expected 0", o_phase); end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL default_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL default_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
  endtask

  task automatic test_mode_change();
    int r;
    clear_queues();
    exp_q = '{1, 3, 7, 11, 27, 43};
    exp_chg_q = '{4, 12};
    do_reset(3'd1, r);
    for (int c = 1; c <= 44; c++) begin
      tick();
      if (c == 8) i_mode = 3'd3;
      #3;
      if (o_mode_chg === 1'b1) chg_q.push_back(c);
      if (c == 11) begin
        checks++; if (o_mode_cur !== 2'd1) begin failures++; $display("[TB] FAIL modechg_before: got %0d expected 1", o_mode_cur); end
      end
      if (c == 12) begin
        checks++; if (o_mode_cur !== 2'd3) begin failures++; $display("[TB] FAIL modechg_after: got %0d expected 3", o_mode_cur); end
      end
    end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL modechg_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL modechg_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
    checks++;
    if (chg_q != exp_chg_q) begin failures++; $display("[TB] FAIL modechg_pulses: got %p expected %p", chg_q, exp_chg_q); end
  endtask

  task automatic test_cancel_last_wins();
    int r;
    clear_queues();
    exp_q = '{1, 3, 19, 35, 37, 39};
    exp_chg_q = '{4, 36};
    do_reset(3'd3, r);
    for (int c = 1; c <= 40; c++) begin
      tick();
      case (c)
        5:  i_mode = 3'd2;
        9:  i_mode = 3'd1;
        13: i_mode = 3'd3;
        20: i_mode = 3'd2;
        24: i_mode = 3'd0;
        default: ;
      endcase
      #3;
      if (o_mode_chg === 1'b1) chg_q.push_back(c);
      if (c == 20) begin
        checks++; if (o_mode_cur !== 2'd3) begin failures++; $display("[TB] FAIL cancel_mode_cur: got %0d expected 3", o_mode_cur); end
      end
      if (c == 36) begin
        checks++; if (o_mode_cur !== 2'd0) begin failures++; $display("[TB] FAIL lastwins_mode_cur: got %0d expected 0", o_mode_cur); end
      end
    end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL cancel_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL cancel_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
    checks++;
    if (chg_q != exp_chg_q) begin failures++; $display("[TB] FAIL cancel_pulses: got %p expected %p", chg_q, exp_chg_q); end
  endtask

  task automatic test_wait();
    int r;
    clear_queues();
    exp_q = '{1, 3, 22, 38, 54};
    do_reset(3'd3, r);
    for (int c = 1; c <= 55; c++) begin
      tick();
      if (c == 17) i_wait_req = 1'b1;
      if (c == 22) i_wait_req = 1'b0;
      #3;
      if (c == 17 || c == 18 || c == 23) begin
        checks++; if (o_wait_ack !== 1'b0) begin failures++; $display("[TB] FAIL wait_ack_low_c%0d: got %b expected 0", c, o_wait_ack); end
      end
      if (c == 20 || c == 21) begin
        checks++; if (o_wait_ack !== 1'b1) begin failures++; $display("[TB] FAIL wait_ack_high_c%0d: got %b expected 1", c, o_wait_ack); end
      end
      if (c == 23) begin
        checks++; if (o_en_cnt !== 16'd3) begin failures++; $display("[TB] FAIL wait_en_cnt: got %0d expected 3", o_en_cnt); end
      end
    end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL wait_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL wait_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
  endtask

  task automatic test_bad_mode();
    int r;
    clear_queues();
    exp_q = '{1, 3, 7, 11, 15, 19, 23};
    exp_err_q = '{11};
    exp_chg_q = '{4};
    do_reset(3'd1, r);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 8)  i_mode = 3'd5;
      if (c == 14) i_mode = 3'd6;
      if (c == 18) i_mode = 3'd1;
      #3;
      if (o_mode_err === 1'b1) err_q.push_back(c);
      if (o_mode_chg === 1'b1) chg_q.push_back(c);
    end
    checks++; if (o_mode_cur !== 2'd1) begin failures++; $display("[TB] FAIL bad_mode_cur: got %0d expected 1", o_mode_cur); end
    checks++;
    if (err_q != exp_err_q) begin failures++; $display("[TB] FAIL bad_err_pulses: got %p expected %p", err_q, exp_err_q); end
    checks++;
    if (chg_q != exp_chg_q) begin failures++; $display("[TB] FAIL bad_chg_pulses: got %p expected %p", chg_q, exp_chg_q); end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL bad_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL bad_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int r;
    clear_queues();
    exp_q = '{1, 3, 24, 26, 34};
    do_reset(3'd3, r);
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 5)  i_mode = 3'd2;
      if (c == 18) i_wait_req = 1'b1;
      if (c == 21) begin i_reset = 1'b1; i_wait_req = 1'b0; end
      if (c == 23) i_reset = 1'b0;
      #3;
      if (c == 20) begin
        checks++; if (o_wait_ack !== 1'b1) begin failures++; $display("[TB] FAIL midwait_in_wait: got %b expected 1", o_wait_ack); end
      end
      if (c == 21) begin
        checks++; if (o_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL midwait_rst_clk_en: got %b expected 0", o_clk_en); end
        checks++; if (o_wait_ack !== 1'b0) begin failures++; $display("[TB] FAIL midwait_rst_wait_ack: got %b expected 0", o_wait_ack); end
      end
      if (c == 23) begin
        checks++; if (o_en_cnt !== 16'd0) begin failures++; $display("[TB] FAIL midwait_en_cnt: got %0d expected 0", o_en_cnt); end
        checks++; if (o_mode_cur !== 2'd0) begin failures++; $display("[TB] FAIL midwait_mode_cur: got %0d expected 0", o_mode_cur); end
        checks++; if (o_phase !== 1'b0) begin failures++; $display("[TB] FAIL midwait_phase: got %b expected 0", o_phase); end
      end
      if (c == 25) begin
        checks++; if (o_mode_cur !== 2'd0) begin failures++; $display("[TB] FAIL midwait_no_stale_mode: got %0d expected 0", o_mode_cur); end
        checks++; if (o_en_cnt !== 16'd1) begin failures++; $display("[TB] FAIL midwait_first_cnt: got %0d expected 1", o_en_cnt); end
      end
      if (c == 27) begin
        checks++; if (o_mode_cur !== 2'd2) begin failures++; $display("[TB] FAIL midwait_new_mode: got %0d expected 2", o_mode_cur); end
      end
    end
    checks++;
    if (seen_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL midwait_strobe_count: got %0d expected %0d", seen_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < seen_q.size()) begin
      checks++;
      if (seen_q[i] - r !== exp_q[i]) begin failures++; $display("[TB] FAIL midwait_strobe_%0d: got cycle %0d expected %0d", i, seen_q[i] - r, exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    int low_cnt;
    low_cnt = 0;
    f_reset = 1'b1; f_wait = 1'b0; f_mode = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    f_reset = 1'b0;
    for (int k = 1; k <= 65537; k++) begin
      tick();
      if (f_clk_en !== 1'b1) low_cnt++;
      if (k == 65535) begin
        checks++; if (f_en_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_ffff: got %h expected ffff", f_en_cnt); end
      end
      if (k == 65536) begin
        checks++; if (f_en_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_zero: got %h expected 0000", f_en_cnt); end
      end
    end
    checks++; if (f_en_cnt !== 16'd1) begin failures++; $display("[TB] FAIL wrap_one: got %0d expected 1", f_en_cnt); end
    checks++; if (low_cnt != 0) begin failures++; $display("[TB] FAIL div1_gaps: got %0d expected 0", low_cnt); end
    f_wait = 1'b1;
    #3;
    checks++; if (f_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL div1_wait_hold: got %b expected 0", f_clk_en); end
    tick(); #3;
    checks++; if (f_wait_ack !== 1'b1) begin failures++; $display("[TB] FAIL div1_wait_ack: got %b expected 1", f_wait_ack); end
    checks++; if (f_clk_en !== 1'b0) begin failures++; $display("[TB] FAIL div1_wait_still: got %b expected 0", f_clk_en); end
    tick();
    f_wait = 1'b0;
    #3;
    checks++; if (f_clk_en !== 1'b1) begin failures++; $display("[TB] FAIL div1_wait_release: got %b expected 1", f_clk_en); end
  endtask

  initial begin
    $display("[TB] starting turbo_clk_gen bench");
    test_reset();
    test_default();
    test_mode_change();
    test_cancel_last_wins();
    test_wait();
    test_bad_mode();
    test_reset_mid_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
